// File: rtl/bincnt_seq_pkg.sv
// Shared definitions for the sequential popcount: FSM encoding, group width, clog2 helper.
// Pure declarations: no latency and no flow control of its own.
// Imported by every bincnt_seq file so encodings and derived widths stay in one place.
package bincnt_seq_pkg;

    localparam int CHUNK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest n with 2**n >= v; used to size the count output.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sorter3b.sv
// 3-input bit sorter: packs the ones of x toward the MSB of y (thermometer code).
// Latency: purely combinational, zero cycles.
// Backpressure: none; a pure function of x.
module sorter3b (
    input  logic [2:0] x,
    output logic [2:0] y
);

    assign y[2] = |x;
    assign y[1] = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    assign y[0] = &x;

endmodule

// File: rtl/bincnt_seq.sv
// Sequential popcount: one sorter3b walks the word 3 bits per cycle, the total is accumulated.
// Latency: NCHUNK edges from accept to out_valid (shorter when BINCNT_SEQ_EARLY_EXIT_EN is defined).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module bincnt_seq
    import bincnt_seq_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CW    = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             busy
);

    localparam int NCHUNK = (WIDTH + CHUNK_W - 1) / CHUNK_W;
    localparam int SW     = NCHUNK * CHUNK_W;
    localparam int CNTW   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

    state_t              state;
    logic [SW-1:0]       shreg;
    logic [CNTW-1:0]     cnt;
    logic [CW-1:0]       acc;
    logic [CW-1:0]       acc_nxt;
    logic [CHUNK_W-1:0]  srt_y;
    logic [1:0]          grp_cnt;
    logic                last;

    sorter3b u_sorter (
        .x (shreg[CHUNK_W-1:0]),
        .y (srt_y)
    );

    // Thermometer to count; order of packing does not matter for the sum.
    assign grp_cnt = {1'b0, srt_y[0]} + {1'b0, srt_y[1]} + {1'b0, srt_y[2]};
    assign acc_nxt = acc + CW'(grp_cnt);

`ifdef BINCNT_SEQ_EARLY_EXIT_EN
    logic rem_zero;
    assign rem_zero = ((shreg >> CHUNK_W) == '0);
    assign last     = (cnt == CNTW'(NCHUNK - 1)) || rem_zero;
`else
    assign last     = (cnt == CNTW'(NCHUNK - 1));
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            acc       <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg <= SW'(in_data);
                        cnt   <= '0;
                        acc   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    shreg <= shreg >> CHUNK_W;
                    cnt   <= cnt + CNTW'(1);
                    if (last) begin
                        out_count <= acc_nxt;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
